// File: rtl/mem_access_unit_if.sv
// Pipeline-side request/response handshake and data-memory bus of the MEM-stage unit.
interface mem_access_unit_if #(
   parameter int unsigned WORD_W   = 32,
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned MEM_OP_W = 4
);
   logic                req_valid;
   logic                req_ready;
   logic [MEM_OP_W-1:0] mem_op;
   logic [ADDR_W-1:0]   addr;
   logic [WORD_W-1:0]   wdata;
   logic                rsp_valid;
   logic [WORD_W-1:0]   rsp_rdata;
   logic                rsp_misalign;
   logic                stall;
   logic                dmem_req;
   logic                dmem_we;
   logic [ADDR_W-1:0]   dmem_addr;
   logic [3:0]          dmem_be;
   logic [WORD_W-1:0]   dmem_wdata;
   logic                dmem_ack;
   logic [WORD_W-1:0]   dmem_rdata;

   // View of the memory access unit itself.
   modport slave (
      input  req_valid, mem_op, addr, wdata, dmem_ack, dmem_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_misalign, stall,
             dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata
   );

   // View of the surrounding pipeline and data memory.
   modport master (
      output req_valid, mem_op, addr, wdata, dmem_ack, dmem_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_misalign, stall,
             dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata
   );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage executor: turns load/store codes into word-aligned byte-enabled
// memory requests, extends load data and returns one response per operation.
module mem_access_unit #(
   parameter int unsigned WORD_W   = 32,
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned MEM_OP_W = 4
) (
   input logic              clk,
   input logic              rst_n,
   mem_access_unit_if.slave bus
);
   // Memory operation encoding shared with the decode stage.
   localparam logic [MEM_OP_W-1:0] MEM_OP_NOP      = MEM_OP_W'(0);
   localparam logic [MEM_OP_W-1:0] MEM_OP_RD_BYTE  = MEM_OP_W'(1);
   localparam logic [MEM_OP_W-1:0] MEM_OP_RD_UBYTE = MEM_OP_W'(2);
   localparam logic [MEM_OP_W-1:0] MEM_OP_RD_HALF  = MEM_OP_W'(3);
   localparam logic [MEM_OP_W-1:0] MEM_OP_RD_UHALF = MEM_OP_W'(4);
   localparam logic [MEM_OP_W-1:0] MEM_OP_RD_WORD  = MEM_OP_W'(5);
   localparam logic [MEM_OP_W-1:0] MEM_OP_WR_BYTE  = MEM_OP_W'(6);
   localparam logic [MEM_OP_W-1:0] MEM_OP_WR_HALF  = MEM_OP_W'(7);
   localparam logic [MEM_OP_W-1:0] MEM_OP_WR_WORD  = MEM_OP_W'(8);

   typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;
   typedef enum logic [1:0] {SzByte, SzHalf, SzWord} size_e;

   state_e              state_q, state_d;
   logic [MEM_OP_W-1:0] op_q, op_d;
   logic [1:0]          lane_q, lane_d;
   logic                dmem_req_q, dmem_req_d;
   logic                dmem_we_q, dmem_we_d;
   logic [ADDR_W-1:0]   dmem_addr_q, dmem_addr_d;
   logic [3:0]          dmem_be_q, dmem_be_d;
   logic [WORD_W-1:0]   dmem_wdata_q, dmem_wdata_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [WORD_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                rsp_misalign_q, rsp_misalign_d;

   logic                op_known, op_write, misalign;
   size_e               op_size;
   logic [3:0]          req_be;
   logic [WORD_W-1:0]   req_wdata;
   logic [7:0]          ld_byte;
   logic [15:0]         ld_half;
   logic [WORD_W-1:0]   ld_data;

   // Decode the incoming operation and format the request it would issue.
   always_comb begin
      op_known = 1'b1;
      op_write = 1'b0;
      op_size  = SzWord;
      case (bus.mem_op)
         MEM_OP_RD_BYTE, MEM_OP_RD_UBYTE: op_size = SzByte;
         MEM_OP_RD_HALF, MEM_OP_RD_UHALF: op_size = SzHalf;
         MEM_OP_RD_WORD:                  op_size = SzWord;
         MEM_OP_WR_BYTE: begin op_size = SzByte; op_write = 1'b1; end
         MEM_OP_WR_HALF: begin op_size = SzHalf; op_write = 1'b1; end
         MEM_OP_WR_WORD: begin op_size = SzWord; op_write = 1'b1; end
         default:        op_known = 1'b0;  // NOP and unrecognised codes
      endcase
      case (op_size)
         SzByte: begin
            req_be    = 4'b0001 << bus.addr[1:0];
            req_wdata = {4{bus.wdata[7:0]}};
         end
         SzHalf: begin
            req_be    = bus.addr[1] ? 4'b1100 : 4'b0011;
            req_wdata = {2{bus.wdata[15:0]}};
         end
         default: begin
            req_be    = 4'b1111;
            req_wdata = bus.wdata;
         end
      endcase
      misalign = ((op_size == SzHalf) && bus.addr[0]) ||
                 ((op_size == SzWord) && (bus.addr[1:0] != 2'b00));
   end

   // Extract and extend the load lane selected by the latched address bits.
   always_comb begin
      ld_byte = bus.dmem_rdata[{lane_q, 3'b000} +: 8];
      ld_half = lane_q[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
      case (op_q)
         MEM_OP_RD_BYTE:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         MEM_OP_RD_UBYTE: ld_data = {24'b0, ld_byte};
         MEM_OP_RD_HALF:  ld_data = {{16{ld_half[15]}}, ld_half};
         MEM_OP_RD_UHALF: ld_data = {16'b0, ld_half};
         MEM_OP_RD_WORD:  ld_data = bus.dmem_rdata;
         default:         ld_data = '0;  // stores respond with zero
      endcase
   end

   // Next-state logic; the memory request is held unchanged until ack.
   always_comb begin
      state_d        = state_q;
      op_d           = op_q;
      lane_d         = lane_q;
      dmem_req_d     = dmem_req_q;
      dmem_we_d      = dmem_we_q;
      dmem_addr_d    = dmem_addr_q;
      dmem_be_d      = dmem_be_q;
      dmem_wdata_d   = dmem_wdata_q;
      rsp_valid_d    = 1'b0;
      rsp_rdata_d    = '0;
      rsp_misalign_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.req_valid) begin
               if (!op_known || misalign) begin
                  state_d        = StResp;
                  rsp_valid_d    = 1'b1;
                  rsp_misalign_d = op_known && misalign;
               end else begin
                  state_d      = StBusy;
                  op_d         = bus.mem_op;
                  lane_d       = bus.addr[1:0];
                  dmem_req_d   = 1'b1;
                  dmem_we_d    = op_write;
                  dmem_addr_d  = {bus.addr[ADDR_W-1:2], 2'b00};
                  dmem_be_d    = req_be;
                  dmem_wdata_d = req_wdata;
               end
            end
         end
         StBusy: begin
            if (bus.dmem_ack) begin
               state_d      = StResp;
               dmem_req_d   = 1'b0;
               dmem_we_d    = 1'b0;
               dmem_addr_d  = '0;
               dmem_be_d    = '0;
               dmem_wdata_d = '0;
               rsp_valid_d  = 1'b1;
               rsp_rdata_d  = ld_data;
            end
         end
         StResp: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // State and output registers; reset aborts any in-flight access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= StIdle;
         op_q           <= MEM_OP_NOP;
         lane_q         <= '0;
         dmem_req_q     <= 1'b0;
         dmem_we_q      <= 1'b0;
         dmem_addr_q    <= '0;
         dmem_be_q      <= '0;
         dmem_wdata_q   <= '0;
         rsp_valid_q    <= 1'b0;
         rsp_rdata_q    <= '0;
         rsp_misalign_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         op_q           <= op_d;
         lane_q         <= lane_d;
         dmem_req_q     <= dmem_req_d;
         dmem_we_q      <= dmem_we_d;
         dmem_addr_q    <= dmem_addr_d;
         dmem_be_q      <= dmem_be_d;
         dmem_wdata_q   <= dmem_wdata_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_rdata_q    <= rsp_rdata_d;
         rsp_misalign_q <= rsp_misalign_d;
      end
   end

   assign bus.req_ready    = (state_q == StIdle);
   assign bus.stall        = (state_q != StIdle);
   assign bus.dmem_req     = dmem_req_q;
   assign bus.dmem_we      = dmem_we_q;
   assign bus.dmem_addr    = dmem_addr_q;
   assign bus.dmem_be      = dmem_be_q;
   assign bus.dmem_wdata   = dmem_wdata_q;
   assign bus.rsp_valid    = rsp_valid_q;
   assign bus.rsp_rdata    = rsp_rdata_q;
   assign bus.rsp_misalign = rsp_misalign_q;
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage executor for the memory operation codes the decode stage produces from `mem_codes.vh` (MEM_OP_RD_*, MEM_OP_WR_*, MEM_OP_NOP).
- Converts each operation into a word-aligned, byte-enabled request to data memory over a req/ack handshake.
- Applies lane extraction and sign/zero extension to load data.
- Returns one response per accepted operation and stalls the pipeline while busy.

Parameters:
- WORD_W, `WORD_W (32): data word width; only 32 is supported.
- ADDR_W, 32: byte address width.
- MEM_OP_W, `MEM_OP_W: width of the mem_op code.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  1  operation presented by the pipeline
- req_ready  output  1  unit can accept an operation this cycle
- mem_op  input  MEM_OP_W  operation code from `mem_codes.vh`
- addr  input  ADDR_W  byte address (ALU result)
- wdata  input  WORD_W  store data (rs2), right-aligned
- rsp_valid  output  1  one-cycle pulse; the response is valid
- rsp_rdata  output  WORD_W  extended load data; 0 for stores, NOP and faults
- rsp_misalign  output  1  qualifies rsp_valid; access was misaligned and not performed
- stall  output  1  pipeline must hold
- dmem_req  output  1  memory request
- dmem_we  output  1  1 = write
- dmem_addr  output  ADDR_W  word address, bits [1:0] = 0
- dmem_be  output  4  byte enables, little-endian
- dmem_wdata  output  WORD_W  lane-replicated write data
- dmem_ack  input  1  memory completion; dmem_rdata is valid in the same cycle for reads
- dmem_rdata  input  WORD_W  read word

Behaviour:
- Reset:
  - State goes to IDLE.
  - All registered outputs are 0: rsp_valid, rsp_rdata, rsp_misalign, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata.
  - req_ready = 1 and stall = 0 while in IDLE.
- States: IDLE, BUSY, RESP.
- req_ready = (state == IDLE). stall = (state != IDLE).
- Acceptance happens in IDLE when req_valid = 1 (cycle T):
  - NOP or any unrecognised code: no memory access. Go to RESP; at T+1, rsp_valid = 1 and rsp_rdata = 0.
  - Misaligned access (half with addr[0] = 1; word with addr[1:0] != 0): no memory access. Go to RESP; at T+1, rsp_valid = 1, rsp_misalign = 1, rsp_rdata = 0.
  - Otherwise: latch op, addr[1:0] and the formatted request. Go to BUSY; dmem_req = 1 from T+1.
- Request formatting:
  - dmem_addr = {addr[ADDR_W-1:2], 2'b00}.
  - Byte: be = 1 << addr[1:0], write data = {4{wdata[7:0]}}.
  - Half: be = addr[1] ? 4'b1100 : 4'b0011, write data = {2{wdata[15:0]}}.
  - Word: be = 4'b1111, write data = wdata.
  - Reads drive be with the same lane pattern and dmem_we = 0.
- BUSY:
  - dmem_req, dmem_we, dmem_addr, dmem_be and dmem_wdata are held stable until dmem_ack.
  - An ack in the first BUSY cycle is legal.
  - On the ack cycle, capture dmem_rdata, drop dmem_req on the next edge and go to RESP.
  - No timeout: the unit waits indefinitely.
- Load extraction uses the latched addr[1:0]:
  - Byte lane k = dmem_rdata[8k+7:8k]. RD_BYTE sign-extends; RD_UBYTE zero-extends.
  - Half lane = addr[1] ? [31:16] : [15:0]. RD_HALF sign-extends; RD_UHALF zero-extends.
  - RD_WORD passes dmem_rdata unchanged.
- Stores: the response carries rsp_rdata = 0.
- RESP:
  - rsp_valid = 1 for exactly one cycle, with rsp_rdata and rsp_misalign registered.
  - Return to IDLE on the next edge.
  - rsp_rdata and rsp_misalign return to 0 when rsp_valid falls.
- Latency: a memory access takes acceptance to rsp_valid = 2 cycles plus ack wait cycles. NOP and misaligned operations take 1 cycle.
- Back-to-back throughput: at most one operation per 2 cycles. req_valid presented outside IDLE is not accepted; the pipeline holds it.
- dmem_ack outside BUSY is ignored.
- Reset mid-operation: dmem_req drops asynchronously and no response is produced for the in-flight operation. A late ack after reset release is ignored.

Test Plan:
- RD_WORD at addr 0x100; ack 3 cycles after dmem_req with dmem_rdata 0xDEADBEEF -> dmem_addr 0x100, dmem_we 0, be 1111, dmem_req held 3 cycles. rsp_valid once, rsp_rdata 0xDEADBEEF, stall high from T+1 through the RESP cycle.
- RD_BYTE at addr 0x103 with dmem_rdata 0x80FF0000 -> be 1000, rsp_rdata 0xFFFFFF80. Repeat with RD_UBYTE -> 0x00000080.
- RD_HALF at addr 0x102 with dmem_rdata 0x80011234 -> rsp_rdata 0xFFFF8001. RD_UHALF -> 0x00008001. RD_HALF at addr 0x100 -> 0x00001234.
- WR_BYTE at addr 0x201 with wdata 0x000000AB -> dmem_addr 0x200, we 1, be 0010, dmem_wdata 0xABABABAB. WR_HALF at addr 0x202 with wdata 0x1234 -> be 1100, dmem_wdata 0x12341234. Both give rsp_rdata 0.
- WR_WORD at addr 0x202 -> no dmem_req. At T+1, rsp_valid = 1 and rsp_misalign = 1. NOP -> rsp_valid at T+1 with rsp_misalign 0 and rsp_rdata 0.
- rst_n low during BUSY before ack -> dmem_req 0 immediately and req_ready 1. A dmem_ack after reset release produces no rsp_valid. A following RD_WORD completes normally.
